// File: rtl/ysyx_22050039_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050039_pkg
// Description : Shared constants for the ysyx_22050039 core front end:
//               IFU state encoding and the default boot PC.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22050039_pkg;

   typedef logic [1:0] ifu_state_t;

   localparam ifu_state_t IFU_BOOT  = 2'd0;
   localparam ifu_state_t IFU_FETCH = 2'd1;
   localparam ifu_state_t IFU_WAIT  = 2'd2;
   localparam ifu_state_t IFU_HOLD  = 2'd3;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

   // A PC is fetchable only on a 4-byte boundary
   function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050039_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050039_pc_gen
// Description : Program counter register with next-PC priority mux:
//               redirect target > sequential pc + 4 > hold.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050039_pc_gen
   import ysyx_22050039_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,            // asynchronous, active-low
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            advance,
   output logic [XLEN-1:0] pc
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Next PC: redirect wins over the sequential step; addition wraps naturally
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (advance) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   // PC register, forced to the boot address while reset is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050039_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22050039_ifu
// Description : Instruction fetch unit. One outstanding fetch at a time,
//               instruction + PC handed to the IDU over valid/ready, PC
//               redirects discard any stale in-flight response.
//               Optional macro YSYX_22050039_IFU_MISALIGN_EN: misaligned PCs
//               are not fetched and instead produce a faulting instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22050039_ifu
   import ysyx_22050039_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter int              INST_LEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst,             // asynchronous, active-low
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [XLEN-1:0]     imem_req_addr,
   input  logic                imem_resp_valid,
   input  logic [INST_LEN-1:0] imem_resp_data,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [INST_LEN-1:0] inst,
   output logic [XLEN-1:0]     inst_pc,
   output logic                inst_fault
);

   ifu_state_t          state_q, state_d;
   logic                drop_q, drop_d;
   logic [INST_LEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
   logic                fault_q, fault_d;
   logic [XLEN-1:0]     pc;
   logic                advance;
   logic                misalign;

`ifdef YSYX_22050039_IFU_MISALIGN_EN
   assign misalign = pc_misaligned(pc[1:0]);
`else
   assign misalign = 1'b0;
`endif

   // Sequential step only when the IDU takes the held instruction
   assign advance = (state_q == IFU_HOLD) && inst_ready;

   ysyx_22050039_pc_gen #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance),
      .pc             (pc)
   );

   // State and delivered-instruction registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IFU_BOOT;
         drop_q    <= 1'b0;
         inst_q    <= '0;
         inst_pc_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         drop_q    <= drop_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
      end
   end

   // Next-state logic including stale-response tracking
   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;
      case (state_q)
         IFU_BOOT: begin
            state_d = IFU_FETCH;
         end
         IFU_FETCH: begin
            if (misalign) begin
               // No request was issued; a redirect simply retargets the fetch
               if (!redirect_valid) begin
                  state_d   = IFU_HOLD;
                  inst_d    = '0;
                  inst_pc_d = pc;
                  fault_d   = 1'b1;
               end
            end else if (imem_req_ready) begin
               state_d = IFU_WAIT;
               drop_d  = redirect_valid;
            end
         end
         IFU_WAIT: begin
            if (imem_resp_valid) begin
               // A redirect landing with the response makes it stale as well;
               // the fetch is complete so there is nothing left to wait for
               if (drop_q || redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = IFU_FETCH;
               end else begin
                  inst_d    = imem_resp_data;
                  inst_pc_d = pc;
                  fault_d   = 1'b0;
                  state_d   = IFU_HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         IFU_HOLD: begin
            if (redirect_valid || inst_ready) begin
               state_d = IFU_FETCH;
               fault_d = 1'b0;
            end
         end
         default: begin
            state_d = IFU_BOOT;
         end
      endcase
   end

   // Handshake valids decode directly from the registered state
   always_comb begin
      imem_req_valid = (state_q == IFU_FETCH) && !misalign;
      inst_valid     = (state_q == IFU_HOLD);
   end

   assign imem_req_addr = pc;
   assign inst          = inst_q;
   assign inst_pc       = inst_pc_q;
   assign inst_fault    = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_ifu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22050039_ifu
// Description : Scoreboard bench for the IFU: stimulus pushes expected fetch
//               addresses and delivered instructions, monitors pop/compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050039_ifu;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   typedef struct packed {
      logic [31:0] word;
      logic [63:0] pc;
      logic        fault;
   } inst_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_fault;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          req_lat  = 1;
   bit          poison   = 1'b0;
   logic [63:0] exp_addr_q[$];
   inst_exp_t   exp_inst_q[$];

   always #5 clk = ~clk;

   ysyx_22050039_ifu dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_fault      (inst_fault)
   );

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[15:0], 16'h0013};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      @(negedge clk);
      while (!(imem_req_valid && imem_req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no request handshake, expected one within 50 cycles", name);
      end
   endtask

   task automatic wait_inst(input string name);
      int n = 0;
      @(negedge clk);
      while (!inst_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got no inst_valid, expected one within 50 cycles", name);
      end
   endtask

   // Memory model: one response req_lat cycles after each accepted request
   initial begin
      logic [63:0] addr;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst && imem_req_valid && imem_req_ready) begin
            addr = imem_req_addr;
            @(posedge clk);
            repeat (req_lat - 1) @(posedge clk);
            #1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = poison ? 32'hDEAD_BEEF : mem_word(addr);
            poison          = 1'b0;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
         end
      end
   end

   // Request monitor: every accepted fetch must match the next expected address
   always @(negedge clk) begin
      if (rst && imem_req_valid && imem_req_ready) begin
         if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got addr %0h, expected no request", imem_req_addr);
         end else begin
            check("req_addr", imem_req_addr, exp_addr_q.pop_front());
         end
      end
   end

   // Delivery monitor: stale data never shown, consumed instructions in order
   always @(negedge clk) begin
      if (rst && inst_valid) begin
         check("no_stale_inst", {31'd0, inst == 32'hDEAD_BEEF}, '0);
         if (inst_ready) begin
            if (exp_inst_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL inst_unexpected: got inst %0h pc %0h, expected none", inst, inst_pc);
            end else begin
               check("inst_out", {inst, inst_pc, inst_fault}, exp_inst_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b0;
      step();
      step();
      @(negedge clk);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_fault", inst_fault, 0);

      // Reset release and first fetch
      exp_addr_q.push_back(RST_PC);
      exp_inst_q.push_back({32'h0000_0013, RST_PC, 1'b0});
      step();
      rst = 1'b1;
      @(negedge clk);
      check("boot_no_req", imem_req_valid, 0);
      step();
      @(negedge clk);
      check("first_req_valid", imem_req_valid, 1);
      step();
      @(negedge clk);
      check("wait_no_inst", inst_valid, 0);
      step();
      @(negedge clk);
      check("first_inst_valid", {inst_valid, inst, inst_pc}, {1'b1, 32'h0000_0013, RST_PC});

      // IDU backpressure
      repeat (5) begin
         step();
         @(negedge clk);
         check("bp_hold", {inst_valid, imem_req_valid, inst, inst_pc}, {1'b1, 1'b0, 32'h0000_0013, RST_PC});
      end
      exp_addr_q.push_back(RST_PC + 64'h4);
      exp_inst_q.push_back({32'h0004_0013, RST_PC + 64'h4, 1'b0});
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      wait_inst("t_seq");

      // Redirect while waiting for the response
      req_lat = 3;
      poison  = 1'b1;
      exp_addr_q.push_back(RST_PC + 64'h8);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      wait_req("t_wait_req");
      step();
      redirect_valid = 1'b1;
      redirect_pc    = RST_PC + 64'h100;
      exp_addr_q.push_back(RST_PC + 64'h100);
      exp_inst_q.push_back({32'h0100_0013, RST_PC + 64'h100, 1'b0});
      step();
      redirect_valid = 1'b0;
      wait_inst("t_wait_inst");
      check("redir_wait_inst", {inst, inst_pc}, {32'h0100_0013, RST_PC + 64'h100});

      // Redirect with inst_ready in HOLD, then redirect with request handshake
      req_lat = 1;
      step();
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = RST_PC + 64'h200;
      exp_addr_q.push_back(RST_PC + 64'h200);
      step();
      inst_ready  = 1'b0;
      redirect_pc = RST_PC + 64'h300;
      poison      = 1'b1;
      exp_addr_q.push_back(RST_PC + 64'h300);
      exp_inst_q.push_back({32'h0300_0013, RST_PC + 64'h300, 1'b0});
      step();
      redirect_valid = 1'b0;
      wait_inst("t_hs_inst");
      check("redir_hs_inst", {inst, inst_pc}, {32'h0300_0013, RST_PC + 64'h300});

      // Memory stall: 3 cycles not ready, then 4-cycle response latency
      imem_req_ready = 1'b0;
      req_lat        = 4;
      exp_addr_q.push_back(RST_PC + 64'h304);
      exp_inst_q.push_back({32'h0304_0013, RST_PC + 64'h304, 1'b0});
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_req", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 64'h304});
         step();
      end
      imem_req_ready = 1'b1;
      step();
      repeat (3) begin
         @(negedge clk);
         check("lat_wait", {imem_req_valid, inst_valid}, 2'b00);
         step();
      end
      wait_inst("t_stall");

      // Misaligned redirect target
      req_lat = 1;
      step();
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = RST_PC + 64'h2;
`ifdef YSYX_22050039_IFU_MISALIGN_EN
      exp_inst_q.push_back({32'h0, RST_PC + 64'h2, 1'b1});
`else
      exp_addr_q.push_back(RST_PC + 64'h2);
      exp_inst_q.push_back({32'h0002_0013, RST_PC + 64'h2, 1'b0});
`endif
      step();
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clk);
`ifdef YSYX_22050039_IFU_MISALIGN_EN
      check("misalign_no_req", imem_req_valid, 0);
`else
      check("misalign_req", {imem_req_valid, imem_req_addr}, {1'b1, RST_PC + 64'h2});
`endif
      wait_inst("t_misalign");
`ifdef YSYX_22050039_IFU_MISALIGN_EN
      check("misalign_hold", {inst, inst_pc, inst_fault}, {32'h0, RST_PC + 64'h2, 1'b1});
`else
      check("misalign_hold", {inst, inst_pc, inst_fault}, {32'h0002_0013, RST_PC + 64'h2, 1'b0});
`endif

      // PC wraps modulo 2^64
      step();
      inst_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
      exp_inst_q.push_back({32'hFFFC_0013, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0});
      exp_addr_q.push_back(64'h0);
      exp_inst_q.push_back({32'h0000_0013, 64'h0, 1'b0});
      step();
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      wait_inst("t_wrap1");
      check("fault_cleared", inst_fault, 0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      wait_inst("t_wrap2");
      check("wrap_pc", inst_pc, 64'h0);

      // Asynchronous reset in the middle of an outstanding fetch
      exp_addr_q.push_back(64'h4);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      wait_req("t_rst_req");
      step();
      #2;
      rst = 1'b0;
      #1;
      check("async_rst", {imem_req_valid, inst_valid, inst_fault, inst, inst_pc}, '0);
      check("async_rst_pc", imem_req_addr, RST_PC);
      exp_addr_q.push_back(RST_PC);
      exp_inst_q.push_back({32'h0000_0013, RST_PC, 1'b0});
      step();
      step();
      rst = 1'b1;
      wait_inst("t_rst_inst");
      imem_req_ready = 1'b0;
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      step();

      check("addr_q_empty", exp_addr_q.size(), 0);
      check("inst_q_empty", exp_inst_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
